huffman_packer: RTL and testbench

- Stage directly downstream of the Huffman table builder.
- Once code_valid is high, captures the six code/mask pairs (HC1..HC6, M1..M6).
- Re-reads the gray-level symbol stream and packs the variable-length codes, MSB first, into an 8-bit byte stream with valid/ready handshake.
- Pads the final partial byte and then pulses done.

---
 rtl/huffman_packer_if.sv | 34 +++
 rtl/huffman_packer.sv | 200 ++++++++++++++++++++
 tb/tb_huffman_packer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_packer_if.sv
// rtl/huffman_packer_if.sv - symbol-in / byte-out handshake bundle for huffman_packer
//
// Purpose: groups the symbol input stream and the packed byte output stream.
// Signals:
//   sym_valid  : symbol present (upstream -> packer)
//   sym_data   : symbol value, legal range 1..6 (upstream -> packer)
//   sym_last   : final symbol marker, qualified by sym_valid (upstream -> packer)
//   sym_ready  : packer can accept a symbol (packer -> upstream)
//   byte_valid : byte_data valid (packer -> downstream)
//   byte_data  : packed byte, first code bit in bit 7 (packer -> downstream)
//   byte_ready : downstream accepts the byte (downstream -> packer)
// Modports: master = packer side, slave = environment side.

interface huffman_packer_if #(
  parameter int SYM_W = 8
);
  logic             sym_valid;
  logic [SYM_W-1:0] sym_data;
  logic             sym_last;
  logic             sym_ready;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;

  modport master (
    input  sym_valid, sym_data, sym_last, byte_ready,
    output sym_ready, byte_valid, byte_data
  );

  modport slave (
    output sym_valid, sym_data, sym_last, byte_ready,
    input  sym_ready, byte_valid, byte_data
  );
endinterface

// File: rtl/huffman_packer.sv
// rtl/huffman_packer.sv - packs Huffman codes of a symbol stream MSB-first into bytes
//
// Purpose: latches the six code/mask pairs once code_valid is high, then maps
// each incoming symbol to its variable-length code and packs the codes into an
// 8-bit byte stream. The final partial byte is padded, then done pulses.
// Optional feature macro: PAD_ONES_EN (defined: pad bits are 1, else 0).
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   code_valid : code table valid (level)
//   HC1..HC6   : code values for symbols 1..6, right-aligned
//   M1..M6     : code masks, contiguous ones from bit 0; length = popcount
//   bus        : huffman_packer_if.master (symbol stream in, byte stream out)
//   sym_err    : sticky, an illegal symbol was accepted
//   done       : one-cycle pulse after the last byte is accepted

module huffman_packer #(
  parameter int BUF_W = 16,
  parameter int SYM_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   code_valid,
  input  logic [7:0]             HC1,
  input  logic [7:0]             HC2,
  input  logic [7:0]             HC3,
  input  logic [7:0]             HC4,
  input  logic [7:0]             HC5,
  input  logic [7:0]             HC6,
  input  logic [7:0]             M1,
  input  logic [7:0]             M2,
  input  logic [7:0]             M3,
  input  logic [7:0]             M4,
  input  logic [7:0]             M5,
  input  logic [7:0]             M6,
  huffman_packer_if.master       bus,
  output logic                   sym_err,
  output logic                   done
);

  localparam int CW = $clog2(BUF_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [BUF_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             sym_err_q, sym_err_d;

  // Table: codes stored already masked so only the low L bits can be set.
  logic [7:0]       hc_q  [0:5];
  logic [3:0]       len_q [0:5];
  logic [7:0]       hc_in [0:5];
  logic [7:0]       m_in  [0:5];
  logic             table_load;

  assign hc_in[0] = HC1;  assign m_in[0] = M1;
  assign hc_in[1] = HC2;  assign m_in[1] = M2;
  assign hc_in[2] = HC3;  assign m_in[2] = M3;
  assign hc_in[3] = HC4;  assign m_in[3] = M4;
  assign hc_in[4] = HC5;  assign m_in[4] = M5;
  assign hc_in[5] = HC6;  assign m_in[5] = M6;

  logic             sym_ready;
  logic             slot_free;
  logic             accept;
  logic             sym_legal;
  logic [2:0]       sym_idx;
  logic [7:0]       code_sel;
  logic [3:0]       len_sel;
  logic             emit_full;
  logic             emit_pad;
  logic [BUF_W-1:0] acc_e;
  logic [CW-1:0]    cnt_e;
  logic [CW-1:0]    shamt;
  logic [BUF_W-1:0] code_ext;
  logic [7:0]       pad_fill;

  assign sym_ready = (state_q == S_RUN) && (cnt_q < CW'(8));
  assign slot_free = !byte_valid_q || bus.byte_ready;
  assign accept    = bus.sym_valid && sym_ready;
  assign sym_legal = (bus.sym_data >= SYM_W'(1)) && (bus.sym_data <= SYM_W'(6));
  assign sym_idx   = sym_legal ? (bus.sym_data[2:0] - 3'd1) : 3'd0;
  assign code_sel  = hc_q[sym_idx];
  assign len_sel   = len_q[sym_idx];

  // Bits below the held cnt bits of acc are always zero, so the padded byte
  // only needs the pad pattern OR-ed in below the remaining bits.
`ifdef PAD_ONES_EN
  assign pad_fill = 8'hFF >> cnt_q;
`else
  assign pad_fill = 8'h00;
`endif

  assign emit_full = ((state_q == S_RUN) || (state_q == S_FLUSH)) &&
                     (cnt_q >= CW'(8)) && slot_free;
  assign emit_pad  = (state_q == S_FLUSH) && (cnt_q != '0) &&
                     (cnt_q < CW'(8)) && slot_free;
  assign table_load = (state_q == S_IDLE) && code_valid;

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    state_d      = state_q;
    byte_valid_d = byte_valid_q;
    byte_data_d  = byte_data_q;
    sym_err_d    = sym_err_q;
    acc_e        = acc_q;
    cnt_e        = cnt_q;
    shamt        = '0;
    code_ext     = '0;

    // Output slot: load a new byte, or retire the current one on handshake.
    if (emit_full) begin
      byte_valid_d = 1'b1;
      byte_data_d  = acc_q[BUF_W-1 -: 8];
      acc_e        = acc_q << 8;
      cnt_e        = cnt_q - CW'(8);
    end else if (emit_pad) begin
      byte_valid_d = 1'b1;
      byte_data_d  = acc_q[BUF_W-1 -: 8] | pad_fill;
      acc_e        = '0;
      cnt_e        = '0;
    end else if (bus.byte_ready) begin
      byte_valid_d = 1'b0;
    end

    // Append the accepted code directly below the bits still held after
    // any emission this cycle.
    if (accept && sym_legal) begin
      code_ext = {{(BUF_W-8){1'b0}}, code_sel};
      shamt    = CW'(BUF_W) - cnt_e - CW'(len_sel);
      acc_d    = acc_e | (code_ext << shamt);
      cnt_d    = cnt_e + CW'(len_sel);
    end else begin
      acc_d    = acc_e;
      cnt_d    = cnt_e;
    end

    if (accept && !sym_legal) begin
      sym_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (code_valid) state_d = S_RUN;
      end
      S_RUN: begin
        if (accept && bus.sym_last) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // Nothing left to pack and the last byte is leaving (or gone).
        if ((cnt_q == '0) && slot_free) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      sym_err_q    <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        hc_q[i]  <= 8'h00;
        len_q[i] <= 4'd0;
      end
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      sym_err_q    <= sym_err_d;
      if (table_load) begin
        for (int i = 0; i < 6; i++) begin
          hc_q[i]  <= hc_in[i] & m_in[i];
          len_q[i] <= 4'($countones(m_in[i]));
        end
      end
    end
  end

  assign bus.sym_ready  = sym_ready;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign sym_err        = sym_err_q;
  assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_huffman_packer.sv
// tb/tb_huffman_packer.sv - self-checking bench for huffman_packer

`timescale 1ns/1ps

module tb_huffman_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       code_valid;
  logic [7:0] tb_hc [1:6];
  logic [7:0] tb_m  [1:6];
  logic       sym_err;
  logic       done;

  huffman_packer_if #(.SYM_W(8)) bus ();

  huffman_packer #(.BUF_W(16), .SYM_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .HC1        (tb_hc[1]),
    .HC2        (tb_hc[2]),
    .HC3        (tb_hc[3]),
    .HC4        (tb_hc[4]),
    .HC5        (tb_hc[5]),
    .HC6        (tb_hc[6]),
    .M1         (tb_m[1]),
    .M2         (tb_m[2]),
    .M3         (tb_m[3]),
    .M4         (tb_m[4]),
    .M5         (tb_m[5]),
    .M6         (tb_m[6]),
    .bus        (bus),
    .sym_err    (sym_err),
    .done       (done)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_q[$];
  int         syms_q[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

`ifdef PAD_ONES_EN
  localparam logic PAD_BIT = 1'b1;
`else
  localparam logic PAD_BIT = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected event, expected normal completion", name);
  endtask

  // Bit-string model: concatenate codes MSB first, cut into bytes, pad tail.
  task automatic build_model();
    logic       bits[$];
    logic [7:0] b;
    int         len;
    int         s;
    int         n;
    model_q.delete();
    foreach (syms_q[i]) begin
      s = syms_q[i];
      if (s >= 1 && s <= 6) begin
        len = $countones(tb_m[s]);
        for (int k = len - 1; k >= 0; k--) bits.push_back(tb_hc[s][k]);
      end
    end
    while (bits.size() >= 8) begin
      for (int j = 0; j < 8; j++) b[7-j] = bits.pop_front();
      model_q.push_back(b);
    end
    if (bits.size() > 0) begin
      b = {8{PAD_BIT}};
      n = bits.size();
      for (int j = 0; j < n; j++) b[7-j] = bits.pop_front();
      model_q.push_back(b);
    end
  endtask

  // Compare process: every handshake byte against the model, hold stability
  // under backpressure, and an empty expectation queue whenever done pulses.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", {31'd0, bus.byte_valid}, 32'd1);
        check("hold_data", {24'd0, bus.byte_data}, {24'd0, prev_data});
      end
      if (bus.byte_valid && bus.byte_ready) begin
        if (exp_q.size() == 0) fail_now("extra_byte");
        else check("byte", {24'd0, bus.byte_data}, {24'd0, exp_q.pop_front()});
      end
      if (done) begin
        check("done_queue_empty", exp_q.size(), 32'd0);
        done_cnt++;
      end
      prev_hold <= bus.byte_valid && !bus.byte_ready;
      prev_data <= bus.byte_data;
    end
  end

  task automatic send_sym(input int s, input logic last);
    int k;
    k = 0;
    bus.sym_valid = 1'b1;
    bus.sym_data  = s[7:0];
    bus.sym_last  = last;
    @(negedge clk);
    while (!bus.sym_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.sym_ready) fail_now("sym_accept_timeout");
    @(posedge clk);
    #1;
    bus.sym_valid = 1'b0;
    bus.sym_last  = 1'b0;
    bus.sym_data  = 8'h00;
  endtask

  task automatic wait_done(input int start);
    int k;
    k = 0;
    while (done_cnt == start && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == start) begin
      fail_now("done_timeout");
    end else begin
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("bytes_all_seen", exp_q.size(), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream();
    int start;
    build_model();
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    start = done_cnt;
    foreach (syms_q[i]) send_sym(syms_q[i], (i == syms_q.size() - 1));
    wait_done(start);
  endtask

  initial begin
    tb_hc[1] = 8'h01; tb_m[1] = 8'h01;
    tb_hc[2] = 8'h01; tb_m[2] = 8'h03;
    tb_hc[3] = 8'h01; tb_m[3] = 8'h07;
    tb_hc[4] = 8'h01; tb_m[4] = 8'h0F;
    tb_hc[5] = 8'h01; tb_m[5] = 8'h1F;
    tb_hc[6] = 8'h00; tb_m[6] = 8'h1F;
    reset          = 1'b1;
    code_valid     = 1'b1;
    bus.sym_valid  = 1'b0;
    bus.sym_data   = 8'h00;
    bus.sym_last   = 1'b0;
    bus.byte_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sym_ready", {31'd0, bus.sym_ready}, 32'd0);
    check("rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
    check("rst_byte_data", {24'd0, bus.byte_data}, 32'd0);
    check("rst_sym_err", {31'd0, sym_err}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Pin the model against hand-computed bytes.
    syms_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    build_model();
    check("model_s1_count", model_q.size(), 32'd1);
    check("model_s1_byte", {24'd0, model_q[0]}, 32'hFF);
    syms_q = '{2, 3};
    build_model();
    check("model_s23_count", model_q.size(), 32'd1);
    check("model_s23_byte", {24'd0, model_q[0]}, PAD_BIT ? 32'h4F : 32'h48);
    syms_q = '{6, 6};
    build_model();
    check("model_s66_count", model_q.size(), 32'd2);
    check("model_s66_b0", {24'd0, model_q[0]}, 32'h00);
    check("model_s66_b1", {24'd0, model_q[1]}, PAD_BIT ? 32'h3F : 32'h00);

    // Eight 1-bit codes: exactly one whole byte, no pad byte.
    syms_q = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_stream();
    syms_q = '{2, 3};
    run_stream();
    syms_q = '{6, 6};
    run_stream();

    // Backpressure: first 0x11 parks in the slot, second fills acc, input stalls.
    syms_q = '{4, 4, 4, 4};
    build_model();
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    bus.byte_ready = 1'b0;
    begin
      int start;
      start = done_cnt;
      foreach (syms_q[i]) send_sym(syms_q[i], (i == 3));
      repeat (3) @(negedge clk);
      check("bp_byte_valid", {31'd0, bus.byte_valid}, 32'd1);
      check("bp_byte_data", {24'd0, bus.byte_data}, 32'h11);
      check("bp_sym_ready", {31'd0, bus.sym_ready}, 32'd0);
      @(posedge clk);
      #1;
      bus.byte_ready = 1'b1;
      wait_done(start);
    end

    // Illegal symbol mid-stream is dropped and flags sym_err.
    syms_q = '{2, 7, 3};
    run_stream();
    check("err_set", {31'd0, sym_err}, 32'd1);
    // Zero-length stream: lone illegal last symbol.
    syms_q = '{7};
    run_stream();
    check("err_sticky", {31'd0, sym_err}, 32'd1);
    // Mixed longer stream.
    syms_q = '{5, 1, 3, 6, 2, 4, 1, 1, 5};
    run_stream();
    check("err_still_sticky", {31'd0, sym_err}, 32'd1);

    // Reset mid-RUN with 5 bits buffered.
    send_sym(5, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_sym_ready", {31'd0, bus.sym_ready}, 32'd0);
    check("mid_rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
    check("mid_rst_byte_data", {24'd0, bus.byte_data}, 32'd0);
    check("mid_rst_sym_err", {31'd0, sym_err}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rerun_sym_ready", {31'd0, bus.sym_ready}, 32'd1);
    @(posedge clk);
    #1;
    syms_q = '{2, 3};
    run_stream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
